// File: rtl/npu_ifm_pkg.sv
// Shared definitions for the IFM chunk ping-pong control path.
`ifndef MEM_SIZE
`define MEM_SIZE 128
`endif
`ifndef BUS_SIZE
`define BUS_SIZE 32
`endif
`ifndef COMPUTE_UNIT_NUM
`define COMPUTE_UNIT_NUM 4
`endif

package npu_ifm_pkg;

  // Read-side FSM: wait for a full buffer, announce it, wait for all units, release it.
  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StRelease
  } rd_state_e;

  // Number of write beats needed to fill one chunk buffer.
  function automatic int unsigned wr_cyc_num(input int unsigned mem_size,
                                             input int unsigned bus_size);
    return mem_size / bus_size;
  endfunction

  // Beat counter width; kept at least one bit wide for degenerate single-beat chunks.
  function automatic int unsigned wr_cnt_width(input int unsigned mem_size,
                                               input int unsigned bus_size);
    int unsigned n;
    n = mem_size / bus_size;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ifm_chunk_pingpong_ctrl.sv
// Ping-pong controller for two IFM chunk buffers: fills one buffer from the upstream beat
// stream while the compute units consume the other, releasing a buffer once every enabled
// unit has reported its last sparsemap word.
`ifndef MEM_SIZE
`define MEM_SIZE 128
`endif
`ifndef BUS_SIZE
`define BUS_SIZE 32
`endif
`ifndef COMPUTE_UNIT_NUM
`define COMPUTE_UNIT_NUM 4
`endif

module ifm_chunk_pingpong_ctrl
  import npu_ifm_pkg::*;
#(
  parameter int unsigned MEM_SIZE = `MEM_SIZE,
  parameter int unsigned BUS_SIZE = `BUS_SIZE,
  parameter int unsigned CU_NUM   = `COMPUTE_UNIT_NUM,
  localparam int unsigned WrCycNum = wr_cyc_num(MEM_SIZE, BUS_SIZE),
  localparam int unsigned CntW     = wr_cnt_width(MEM_SIZE, BUS_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [BUS_SIZE-1:0]   in_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0] in_data_i,
  output logic                  wr_valid_o,
  output logic                  wr_sel_o,
  output logic [CntW-1:0]       wr_count_o,
  output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
  output logic                  chunk_start_o,
  output logic                  rd_sel_o,
  input  logic [CU_NUM-1:0]     cu_en_i,
  input  logic [CU_NUM-1:0]     cu_done_i,
  output logic [1:0]            full_o,
  output logic                  busy_o,
  output logic [15:0]           chunk_cnt_o
);

  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        full_q, full_d;
  logic [1:0]        fill_set, fill_clr;
  logic [CU_NUM-1:0] done_q, done_d;
  logic [15:0]       chunk_cnt_q, chunk_cnt_d;
  rd_state_e         state_q, state_d;
  logic              accept;

  // Write port: handshake and payload pass-through; outputs forced to safe values in reset.
  always_comb begin
    in_ready_o        = rst_i | ~full_q[wr_ptr_q];
    accept            = in_valid_i & ~rst_i & ~full_q[wr_ptr_q];
    wr_valid_o        = accept;
    wr_sel_o          = wr_ptr_q & ~rst_i;
    wr_count_o        = cnt_q;
    wr_sparsemap_o    = in_sparsemap_i;
    wr_nonzero_data_o = in_data_i;
  end

  // Beat counter and write pointer; the last beat of a chunk marks its buffer full.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    fill_set = 2'b00;
    if (accept) begin
      if (cnt_q == CntW'(WrCycNum - 1)) begin
        cnt_d              = '0;
        wr_ptr_d           = ~wr_ptr_q;
        fill_set[wr_ptr_q] = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Read FSM next-state: done_mask starts with disabled units pre-set so only enabled ones gate.
  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    rd_ptr_d    = rd_ptr_q;
    chunk_cnt_d = chunk_cnt_q;
    fill_clr    = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (full_q[rd_ptr_q]) state_d = StStart;
      end
      StStart: begin
        done_d  = ~cu_en_i;
        state_d = StRun;
      end
      StRun: begin
        done_d = done_q | cu_done_i;
        if (&done_d) state_d = StRelease;
      end
      StRelease: begin
        fill_clr[rd_ptr_q] = 1'b1;
        rd_ptr_d           = ~rd_ptr_q;
        chunk_cnt_d        = chunk_cnt_q + 16'd1;
        state_d            = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Fill and release always hit different buffers, so both can apply in one edge.
  always_comb begin
    full_d = (full_q | fill_set) & ~fill_clr;
  end

  // Read-side outputs.
  always_comb begin
    chunk_start_o = (state_q == StStart) & ~rst_i;
    busy_o        = (state_q != StIdle) & ~rst_i;
    rd_sel_o      = rd_ptr_q & ~rst_i;
    full_o        = full_q;
    chunk_cnt_o   = chunk_cnt_q;
  end

  // State registers with synchronous reset; partial chunks and completion state are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
      full_q      <= 2'b00;
      done_q      <= '0;
      state_q     <= StIdle;
      chunk_cnt_q <= 16'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      done_q      <= done_d;
      state_q     <= state_d;
      chunk_cnt_q <= chunk_cnt_d;
    end
  end

endmodule

// File: tb/tb_ifm_chunk_pingpong_ctrl.sv
// Directed bench for the IFM chunk ping-pong controller with a write-beat scoreboard.
`timescale 1ns / 1ps

module tb_ifm_chunk_pingpong_ctrl;

  localparam int unsigned MemSize = 128;
  localparam int unsigned BusSize = 32;
  localparam int unsigned CuNum   = 4;

  typedef struct {
    logic         sel;
    logic [1:0]   cnt;
    logic [31:0]  sm;
    logic [255:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_sparsemap;
  logic [255:0] in_data;
  logic         wr_valid;
  logic         wr_sel;
  logic [1:0]   wr_count;
  logic [31:0]  wr_sparsemap;
  logic [255:0] wr_data;
  logic         chunk_start;
  logic         rd_sel;
  logic [3:0]   cu_en;
  logic [3:0]   cu_done;
  logic [1:0]   full;
  logic         busy;
  logic [15:0]  chunk_cnt;

  int    n_total = 0;
  int    n_pass  = 0;
  int    n_fail  = 0;
  int    n_beats = 0;
  beat_t sb[$];
  beat_t got;

  ifm_chunk_pingpong_ctrl #(
    .MEM_SIZE(MemSize),
    .BUS_SIZE(BusSize),
    .CU_NUM  (CuNum)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_sparsemap_i   (in_sparsemap),
    .in_data_i        (in_data),
    .wr_valid_o       (wr_valid),
    .wr_sel_o         (wr_sel),
    .wr_count_o       (wr_count),
    .wr_sparsemap_o   (wr_sparsemap),
    .wr_nonzero_data_o(wr_data),
    .chunk_start_o    (chunk_start),
    .rd_sel_o         (rd_sel),
    .cu_en_i          (cu_en),
    .cu_done_i        (cu_done),
    .full_o           (full),
    .busy_o           (busy),
    .chunk_cnt_o      (chunk_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input bit ok, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_total++;
    if (ok) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected slot of the next beat: chunks alternate buffers 0,1,0,... from reset.
  task automatic push_expected();
    beat_t e;
    e.sel  = 1'((n_beats / 4) % 2);
    e.cnt  = 2'(n_beats % 4);
    e.sm   = in_sparsemap;
    e.data = in_data;
    sb.push_back(e);
    n_beats++;
  endtask

  task automatic drive_beat(input bit expect_accept);
    in_valid     = 1'b1;
    in_sparsemap = $urandom;
    in_data      = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
    if (expect_accept) push_expected();
  endtask

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", wr_valid === 1'b0, wr_valid, 1'b0);
      end else begin
        got = sb.pop_front();
        chk("wr_sel", wr_sel === got.sel, wr_sel, got.sel);
        chk("wr_count", wr_count === got.cnt, wr_count, got.cnt);
        chk("wr_sparsemap", wr_sparsemap === got.sm, wr_sparsemap, got.sm);
        chk("wr_data", wr_data === got.data, wr_data, got.data);
      end
    end
  end

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_sparsemap = '0;
    in_data      = '0;
    cu_en        = 4'h0;
    cu_done      = 4'h0;
    repeat (2) tick();
    chk("rst_chunk_start", chunk_start === 1'b0, chunk_start, 1'b0);
    chk("rst_busy", busy === 1'b0, busy, 1'b0);
    chk("rst_rd_sel", rd_sel === 1'b0, rd_sel, 1'b0);
    chk("rst_wr_sel", wr_sel === 1'b0, wr_sel, 1'b0);
    chk("rst_in_ready", in_ready === 1'b1, in_ready, 1'b1);
    chk("rst_full", full === 2'b00, full, 2'b00);
    chk("rst_chunk_cnt", chunk_cnt === 16'd0, chunk_cnt, 16'd0);
    rst = 1'b0;
    tick();

    // Single chunk then completion with scattered done pulses.
    cu_en = 4'hF;
    repeat (4) begin
      drive_beat(1'b1);
      tick();
    end
    in_valid = 1'b0;
    chk("t1_full_t1", full === 2'b01, full, 2'b01);
    chk("t1_no_start_t1", chunk_start === 1'b0, chunk_start, 1'b0);
    chk("t1_wr_sel_next", wr_sel === 1'b1, wr_sel, 1'b1);
    tick();
    chk("t1_start_t2", chunk_start === 1'b1, chunk_start, 1'b1);
    chk("t1_rd_sel", rd_sel === 1'b0, rd_sel, 1'b0);
    chk("t1_busy", busy === 1'b1, busy, 1'b1);
    tick();
    chk("t1_start_low_run", chunk_start === 1'b0, chunk_start, 1'b0);
    cu_done = 4'b0001;
    tick();
    cu_done = 4'b0100;
    tick();
    cu_done = 4'b1010;
    tick();
    cu_done = 4'b0000;
    chk("t1_release_busy", busy === 1'b1, busy, 1'b1);
    chk("t1_release_full", full === 2'b01, full, 2'b01);
    tick();
    chk("t1_full_cleared", full === 2'b00, full, 2'b00);
    chk("t1_chunk_cnt", chunk_cnt === 16'd1, chunk_cnt, 16'd1);
    chk("t1_idle", busy === 1'b0, busy, 1'b0);

    rst = 1'b1;
    tick();
    chk("rst2_chunk_cnt", chunk_cnt === 16'd0, chunk_cnt, 16'd0);
    rst     = 1'b0;
    n_beats = 0;

    // Backpressure: both buffers full, ninth beat held until buffer 0 is released.
    repeat (8) begin
      drive_beat(1'b1);
      tick();
    end
    drive_beat(1'b0);
    #1;
    chk("t2_ready_low", in_ready === 1'b0, in_ready, 1'b0);
    chk("t2_no_write", wr_valid === 1'b0, wr_valid, 1'b0);
    chk("t2_full_both", full === 2'b11, full, 2'b11);
    chk("t2_busy", busy === 1'b1, busy, 1'b1);
    repeat (3) tick();
    chk("t2_still_held", in_ready === 1'b0, in_ready, 1'b0);
    cu_done = 4'hF;
    tick();
    cu_done = 4'h0;
    chk("t2_ready_in_release", in_ready === 1'b0, in_ready, 1'b0);
    push_expected();
    tick();
    chk("t2_ready_back", in_ready === 1'b1, in_ready, 1'b1);
    chk("t2_full_after_rel", full === 2'b10, full, 2'b10);
    chk("t2_wr_valid", wr_valid === 1'b1, wr_valid, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t2_start_buf1", chunk_start === 1'b1, chunk_start, 1'b1);
    chk("t2_rd_sel1", rd_sel === 1'b1, rd_sel, 1'b1);
    chk("t2_wr_count", wr_count === 2'd1, wr_count, 2'd1);
    chk("t2_chunk_cnt1", chunk_cnt === 16'd1, chunk_cnt, 16'd1);
    cu_done = 4'hF;  // must be ignored in START
    tick();
    cu_done = 4'h0;
    repeat (2) tick();
    chk("t2_run_held", busy === 1'b1, busy, 1'b1);
    chk("t2_run_full", full === 2'b10, full, 2'b10);
    cu_done = 4'hF;
    tick();
    cu_done = 4'h0;
    chk("t2_rel_full", full === 2'b10, full, 2'b10);
    tick();
    chk("t2_full_done", full === 2'b00, full, 2'b00);
    chk("t2_chunk_cnt2", chunk_cnt === 16'd2, chunk_cnt, 16'd2);
    chk("t2_idle", busy === 1'b0, busy, 1'b0);

    // Masked units: only units 0 and 1 are waited on.
    cu_en = 4'b0011;
    repeat (3) begin
      drive_beat(1'b1);
      tick();
    end
    in_valid = 1'b0;
    chk("t3_full", full === 2'b01, full, 2'b01);
    tick();
    chk("t3_start", chunk_start === 1'b1, chunk_start, 1'b1);
    chk("t3_rd_sel", rd_sel === 1'b0, rd_sel, 1'b0);
    tick();
    cu_done = 4'b0001;
    tick();
    cu_done = 4'b0010;
    tick();
    cu_done = 4'b0000;
    chk("t3_release_busy", busy === 1'b1, busy, 1'b1);
    tick();
    chk("t3_full_cleared", full === 2'b00, full, 2'b00);
    chk("t3_chunk_cnt", chunk_cnt === 16'd3, chunk_cnt, 16'd3);

    // Zero mask: RUN lasts one cycle.
    cu_en = 4'b0000;
    repeat (4) begin
      drive_beat(1'b1);
      tick();
    end
    in_valid = 1'b0;
    chk("t4_full", full === 2'b10, full, 2'b10);
    tick();
    chk("t4_start", chunk_start === 1'b1, chunk_start, 1'b1);
    chk("t4_rd_sel", rd_sel === 1'b1, rd_sel, 1'b1);
    tick();
    chk("t4_run_busy", busy === 1'b1, busy, 1'b1);
    chk("t4_run_full", full === 2'b10, full, 2'b10);
    tick();
    chk("t4_rel_busy", busy === 1'b1, busy, 1'b1);
    tick();
    chk("t4_full_cleared", full === 2'b00, full, 2'b00);
    chk("t4_idle", busy === 1'b0, busy, 1'b0);
    chk("t4_chunk_cnt", chunk_cnt === 16'd4, chunk_cnt, 16'd4);

    // Reset mid-fill and mid-RUN.
    cu_en = 4'hF;
    repeat (6) begin
      drive_beat(1'b1);
      tick();
    end
    in_valid = 1'b0;
    chk("t5_busy_run", busy === 1'b1, busy, 1'b1);
    chk("t5_wr_count", wr_count === 2'd2, wr_count, 2'd2);
    chk("t5_full", full === 2'b01, full, 2'b01);
    rst = 1'b1;
    tick();
    chk("t5_rst_full", full === 2'b00, full, 2'b00);
    chk("t5_rst_wr_count", wr_count === 2'd0, wr_count, 2'd0);
    chk("t5_rst_chunk_cnt", chunk_cnt === 16'd0, chunk_cnt, 16'd0);
    chk("t5_rst_busy", busy === 1'b0, busy, 1'b0);
    chk("t5_rst_in_ready", in_ready === 1'b1, in_ready, 1'b1);
    chk("t5_rst_wr_sel", wr_sel === 1'b0, wr_sel, 1'b0);
    chk("t5_rst_rd_sel", rd_sel === 1'b0, rd_sel, 1'b0);
    chk("t5_rst_start", chunk_start === 1'b0, chunk_start, 1'b0);
    rst     = 1'b0;
    n_beats = 0;
    repeat (3) begin
      tick();
      chk("t5_no_start", chunk_start === 1'b0, chunk_start, 1'b0);
      chk("t5_quiet_busy", busy === 1'b0, busy, 1'b0);
    end
    repeat (4) begin
      drive_beat(1'b1);
      tick();
    end
    in_valid = 1'b0;
    chk("t5_refill_full", full === 2'b01, full, 2'b01);
    tick();
    chk("t5_refill_start", chunk_start === 1'b1, chunk_start, 1'b1);
    chk("t5_refill_rd_sel", rd_sel === 1'b0, rd_sel, 1'b0);
    tick();
    chk("sb_drained", sb.size() === 0, sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
